fc_neuron_seq: RTL and testbench

- Time-multiplexed, parametrised fully-connected neuron for the LeNet-5 classifier layers.
- Consumes an N_IN-element input vector and a matching weight vector as a stream of LANES-wide beats. Multiplies per lane, accumulates in an OUT_WIDTH register, adds bias and optionally applies ReLU.
- Returns one result per neuron over a valid/ready handshake.
- Replaces the fully-parallel single-neuron adder tree, so one instance serves any layer size (120/84/10) by parameter.

---
 rtl/fc_neuron_seq_if.sv | 29 ++
 rtl/fc_neuron_seq.sv | 105 ++++++++++
 tb/tb_fc_neuron_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fc_neuron_seq_if.sv
// Handshake and data bundle for fc_neuron_seq: control (start/bias/relu_en/busy),
// input beat stream (valid/ready/data/weights) and result stream (valid/ready/out).
interface fc_neuron_seq_if #(
  parameter int BIT_WIDTH = 32,
  parameter int OUT_WIDTH = 64,
  parameter int LANES     = 4
);
  logic                         start;
  logic [BIT_WIDTH-1:0]         bias;
  logic                         relu_en;
  logic                         busy;
  logic                         in_valid;
  logic                         in_ready;
  logic [BIT_WIDTH*LANES-1:0]   in_data;
  logic [BIT_WIDTH*LANES-1:0]   in_weights;
  logic                         out_valid;
  logic                         out_ready;
  logic [OUT_WIDTH-1:0]         out;

  modport master (
    output start, bias, relu_en, in_valid, in_data, in_weights, out_ready,
    input  busy, in_ready, out_valid, out
  );

  modport slave (
    input  start, bias, relu_en, in_valid, in_data, in_weights, out_ready,
    output busy, in_ready, out_valid, out
  );
endinterface

// File: rtl/fc_neuron_seq.sv
// Time-multiplexed fully-connected neuron: accumulates LANES products per beat
// over BEATS beats, adds bias, optional ReLU, returns result over valid/ready.
module fc_neuron_seq #(
  parameter int BIT_WIDTH = 32,
  parameter int OUT_WIDTH = 64,
  parameter int N_IN      = 120,
  parameter int LANES     = 4
) (
  input logic              clk,
  input logic              rst_n,
  fc_neuron_seq_if.slave   nif
);

  localparam int          BEATS   = (N_IN + LANES - 1) / LANES;
  localparam int          CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LANES_U = LANES;
  localparam int unsigned N_IN_U  = N_IN;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                        state_q, state_d;
  logic signed [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic        [CNT_W-1:0]       cnt_q, cnt_d;
  logic                          relu_q, relu_d;
  logic signed [OUT_WIDTH-1:0]   out_q, out_d;

  logic signed [BIT_WIDTH-1:0]   din  [LANES];
  logic signed [BIT_WIDTH-1:0]   wts  [LANES];
  logic signed [2*BIT_WIDTH-1:0] prod [LANES];
  logic signed [OUT_WIDTH-1:0]   lane_sum;
  logic signed [OUT_WIDTH-1:0]   sum_next;

  // Per-beat lane products and their sum; lanes past N_IN (padding on the final beat) are masked
  always_comb begin
    lane_sum = '0;
    for (int unsigned k = 0; k < LANES_U; k++) begin
      din[k]  = nif.in_data[BIT_WIDTH*k +: BIT_WIDTH];
      wts[k]  = nif.in_weights[BIT_WIDTH*k +: BIT_WIDTH];
      prod[k] = (2*BIT_WIDTH)'(din[k]) * (2*BIT_WIDTH)'(wts[k]);
      if ((32'(cnt_q) * LANES_U + k) < N_IN_U) begin
        lane_sum = lane_sum + OUT_WIDTH'(prod[k]);
      end
    end
    sum_next = acc_q + lane_sum;
  end

  // Next-state and datapath update for IDLE/ACC/DONE
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    relu_d  = relu_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (nif.start) begin
          acc_d   = OUT_WIDTH'($signed(nif.bias));
          relu_d  = nif.relu_en;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (nif.in_valid) begin
          acc_d = sum_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            out_d   = (relu_q && sum_next[OUT_WIDTH-1]) ? '0 : sum_next;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (nif.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      relu_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      relu_q  <= relu_d;
      out_q   <= out_d;
    end
  end

  assign nif.busy      = (state_q != IDLE);
  assign nif.in_ready  = (state_q == ACC);
  assign nif.out_valid = (state_q == DONE);
  assign nif.out       = out_q;

endmodule

// File: tb/tb_fc_neuron_seq.sv
// Directed self-checking bench for fc_neuron_seq at N_IN=8, N_IN=10 and default (120).
module tb_fc_neuron_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fc_neuron_seq_if #(.BIT_WIDTH(32), .OUT_WIDTH(64), .LANES(4)) i8   ();
  fc_neuron_seq_if #(.BIT_WIDTH(32), .OUT_WIDTH(64), .LANES(4)) i10  ();
  fc_neuron_seq_if #(.BIT_WIDTH(32), .OUT_WIDTH(64), .LANES(4)) i120 ();

  fc_neuron_seq #(.BIT_WIDTH(32), .OUT_WIDTH(64), .N_IN(8),   .LANES(4)) u8   (.clk(clk), .rst_n(rst_n), .nif(i8));
  fc_neuron_seq #(.BIT_WIDTH(32), .OUT_WIDTH(64), .N_IN(10),  .LANES(4)) u10  (.clk(clk), .rst_n(rst_n), .nif(i10));
  fc_neuron_seq #(.BIT_WIDTH(32), .OUT_WIDTH(64), .N_IN(120), .LANES(4)) u120 (.clk(clk), .rst_n(rst_n), .nif(i120));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One N_IN=8 neuron: optional stall cycles between the two beats, optional
  // out_ready hold-off in DONE with start pulses that must be ignored.
  task automatic run8(input logic [31:0] b, input logic r,
                      input logic [127:0] d0, input logic [127:0] d1, input logic [127:0] w,
                      input int stall, input int hold, input logic [63:0] exp, input string tag);
    i8.start = 1'b1; i8.bias = b; i8.relu_en = r; i8.in_valid = 1'b0; i8.out_ready = 1'b0;
    step();
    i8.start = 1'b0;
    chk({tag, "_busy_acc"}, 64'(i8.busy), 64'd1);
    chk({tag, "_rdy_acc0"}, 64'(i8.in_ready), 64'd1);
    i8.in_valid = 1'b1; i8.in_data = d0; i8.in_weights = w;
    step();
    chk({tag, "_rdy_acc1"}, 64'(i8.in_ready), 64'd1);
    chk({tag, "_ov_early"}, 64'(i8.out_valid), 64'd0);
    i8.in_valid = 1'b0;
    i8.in_data = pack4(32'd999, 32'd999, 32'd999, 32'd999);
    for (int s = 0; s < stall; s++) begin
      step();
      chk({tag, "_stall_rdy"}, 64'(i8.in_ready), 64'd1);
      chk({tag, "_stall_ov"}, 64'(i8.out_valid), 64'd0);
    end
    i8.in_valid = 1'b1; i8.in_data = d1;
    step();
    i8.in_valid = 1'b0;
    chk({tag, "_ov"}, 64'(i8.out_valid), 64'd1);
    chk({tag, "_out"}, i8.out, exp);
    chk({tag, "_rdy_done"}, 64'(i8.in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      i8.start = 1'b1;
      step();
      chk({tag, "_hold_ov"}, 64'(i8.out_valid), 64'd1);
      chk({tag, "_hold_out"}, i8.out, exp);
      chk({tag, "_hold_rdy"}, 64'(i8.in_ready), 64'd0);
      chk({tag, "_hold_busy"}, 64'(i8.busy), 64'd1);
    end
    i8.out_ready = 1'b1;
    step();
    i8.start = 1'b0; i8.out_ready = 1'b0;
    chk({tag, "_ov_after"}, 64'(i8.out_valid), 64'd0);
    chk({tag, "_busy_after"}, 64'(i8.busy), 64'd0);
    chk({tag, "_out_kept"}, i8.out, exp);
    step();
    chk({tag, "_idle_rdy"}, 64'(i8.in_ready), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    i8.start = 1'b0;   i8.bias = '0;   i8.relu_en = 1'b0;   i8.in_valid = 1'b0;
    i8.in_data = '0;   i8.in_weights = '0;   i8.out_ready = 1'b0;
    i10.start = 1'b0;  i10.bias = '0;  i10.relu_en = 1'b0;  i10.in_valid = 1'b0;
    i10.in_data = '0;  i10.in_weights = '0;  i10.out_ready = 1'b0;
    i120.start = 1'b0; i120.bias = '0; i120.relu_en = 1'b0; i120.in_valid = 1'b0;
    i120.in_data = '0; i120.in_weights = '0; i120.out_ready = 1'b0;

    #3;
    chk("rst_busy",  64'(i8.busy), 64'd0);
    chk("rst_rdy",   64'(i8.in_ready), 64'd0);
    chk("rst_ov",    64'(i8.out_valid), 64'd0);
    chk("rst_out",   i8.out, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // bias 5, data 1..8, weights 2 -> 2*36 + 5
    run8(32'd5, 1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), pack4(2, 2, 2, 2), 0, 0, 64'd77, "basic");

    // N_IN=10: padding lanes on beat 3 carry 1000*1000 and must be masked
    i10.start = 1'b1; i10.bias = '0; i10.relu_en = 1'b0; i10.out_ready = 1'b1;
    step();
    i10.start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      i10.in_valid   = 1'b1;
      i10.in_data    = (b == 2) ? pack4(1, 1, 1000, 1000) : pack4(1, 1, 1, 1);
      i10.in_weights = (b == 2) ? pack4(1, 1, 1000, 1000) : pack4(1, 1, 1, 1);
      chk("pad_rdy", 64'(i10.in_ready), 64'd1);
      step();
    end
    i10.in_valid = 1'b0;
    chk("pad_ov",  64'(i10.out_valid), 64'd1);
    chk("pad_out", i10.out, 64'd10);
    step();
    chk("pad_ov_after", 64'(i10.out_valid), 64'd0);
    i10.out_ready = 1'b0;

    // bias -100 with eight 1*1 products: ReLU clamps, otherwise -92
    run8(-32'sd100, 1'b1, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 0, 0, 64'd0, "relu_on");
    run8(-32'sd100, 1'b0, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 0, 0,
         64'hFFFF_FFFF_FFFF_FFA4, "relu_off");

    // backpressure for 5 cycles with ignored start pulses, then a fresh neuron (weights 3 -> 108)
    run8(32'd5, 1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), pack4(2, 2, 2, 2), 0, 5, 64'd77, "bp");
    run8(32'd0, 1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), pack4(3, 3, 3, 3), 0, 0, 64'd108, "after_bp");

    // in_valid 1,0,0,1 gives the unstalled result
    run8(32'd5, 1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), pack4(2, 2, 2, 2), 2, 0, 64'd77, "stall");

    // N_IN=120 with max positive operands: 120*(2^31-1)^2 wraps mod 2^64
    i120.start = 1'b1; i120.bias = '0; i120.relu_en = 1'b0; i120.out_ready = 1'b0;
    step();
    i120.start = 1'b0;
    i120.in_data    = pack4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    i120.in_weights = pack4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    i120.in_valid   = 1'b1;
    for (int b = 0; b < 30; b++) step();
    i120.in_valid = 1'b0;
    chk("wrap_ov",  64'(i120.out_valid), 64'd1);
    chk("wrap_out", i120.out, 64'hFFFF_FF88_0000_0078);
    i120.out_ready = 1'b1;
    step();
    i120.out_ready = 1'b0;
    chk("wrap_busy_after", 64'(i120.busy), 64'd0);

    // reset mid-accumulation discards the partial sum
    i120.start = 1'b1; i120.bias = 32'd3;
    step();
    i120.start = 1'b0;
    i120.in_valid = 1'b1;
    for (int b = 0; b < 5; b++) step();
    i120.in_valid = 1'b0;
    chk("mid_busy_pre", 64'(i120.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov",   64'(i120.out_valid), 64'd0);
    chk("mid_rst_busy", 64'(i120.busy), 64'd0);
    chk("mid_rst_out",  i120.out, 64'd0);
    chk("mid_rst_rdy",  64'(i120.in_ready), 64'd0);
    #2;
    rst_n = 1'b1;
    step();

    // next neuron after reset: 120 ones + bias 7, ReLU on (positive, passes)
    i120.start = 1'b1; i120.bias = 32'd7; i120.relu_en = 1'b1;
    step();
    i120.start = 1'b0;
    i120.in_data    = pack4(1, 1, 1, 1);
    i120.in_weights = pack4(1, 1, 1, 1);
    i120.in_valid   = 1'b1;
    for (int b = 0; b < 30; b++) step();
    i120.in_valid = 1'b0;
    chk("post_rst_ov",  64'(i120.out_valid), 64'd1);
    chk("post_rst_out", i120.out, 64'd127);
    i120.out_ready = 1'b1;
    step();
    i120.out_ready = 1'b0;
    chk("post_rst_busy", 64'(i120.busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
